// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
// UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits, tx idles high.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (PARITY_ODD selects odd parity).
module uart_tx_engine #(
    parameter int unsigned BAUD_DIV  = 5208,
    parameter int unsigned STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam int unsigned      BaudW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(BAUD_DIV - 1);
    localparam logic             StopMax = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;
    logic parity_q;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             stop_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_end;

    assign bit_end = (baud_q == BaudMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                baud_q <= bit_end ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (load_i) begin
                        state_q  <= StStart;
                        shift_q  <= tx_data_i;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        stop_q   <= 1'b0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        // Parity is taken from the byte as latched, not from the shifting copy.
                        parity_q <= (^tx_data_i) ^ 1'(PARITY_ODD);
`endif
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StPar;
                            tx_q    <= parity_q;
`else
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
`endif
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StPar: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        if (stop_q == StopMax) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
// Bench for uart_tx_engine: two instances (1 and 2 stop bits) checked cycle by cycle against
// a queue of expected {tx, busy, done} samples built from each accepted byte.
module tb_uart_tx_engine;

    localparam int unsigned Baud = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif
    localparam int unsigned FrameLenA = (1 + 8 + ParBits + 1) * Baud;

    logic       clk;
    logic       rst_n;
    logic       load_a, load_b;
    logic [7:0] data_a, data_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    logic [2:0] q_a[$];
    logic [2:0] q_b[$];
    int         n_pass;
    int         n_total;
    int         dones_a;
    int         dones_b;
    int         before_a;
    int         before_b;
    int         frames_a;
    int         frames_b;
    int         n;
    logic [10:0] cap;
    logic [10:0] exp_cap;

    typedef struct {
        logic [7:0] data;
        bit         sel;
        logic       par;
    } vec_t;
    vec_t vecs[8];

`ifdef UART_TX_PARITY_EN
    uart_tx_engine #(.BAUD_DIV(Baud), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_a (
`else
    uart_tx_engine #(.BAUD_DIV(Baud), .STOP_BITS(1)) u_dut_a (
`endif
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (load_a),
        .tx_data_i (data_a),
        .tx_o      (tx_a),
        .tx_busy_o (busy_a),
        .tx_done_o (done_a)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_engine #(.BAUD_DIV(Baud), .STOP_BITS(2), .PARITY_ODD(1)) u_dut_b (
`else
    uart_tx_engine #(.BAUD_DIV(Baud), .STOP_BITS(2)) u_dut_b (
`endif
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (load_b),
        .tx_data_i (data_b),
        .tx_o      (tx_b),
        .tx_busy_o (busy_b),
        .tx_done_o (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Outputs are sampled on the falling edge, half a cycle after each update.
    always @(negedge clk) begin
        logic [2:0] ea;
        logic [2:0] eb;
        ea = 3'b100;
        eb = 3'b100;
        if (q_a.size() > 0) ea = q_a.pop_front();
        if (q_b.size() > 0) eb = q_b.pop_front();
        check("frame_a", 32'({tx_a, busy_a, done_a}), 32'(ea));
        check("frame_b", 32'({tx_b, busy_b, done_b}), 32'(eb));
        if (done_a) dones_a++;
        if (done_b) dones_b++;
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input bit sel, input logic [7:0] d, input logic par);
        logic [12:0] bits;
        int nb;
        bits = '1;
        nb = 0;
        bits[nb] = 1'b0;
        nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i];
            nb++;
        end
`ifdef UART_TX_PARITY_EN
        bits[nb] = par;
        nb++;
`else
        if (par === 1'bx) bits[0] = 1'b0;
`endif
        nb += sel ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < int'(Baud); c++) begin
                if (sel) q_b.push_back({bits[b], 1'b1, 1'b0});
                else q_a.push_back({bits[b], 1'b1, 1'b0});
            end
        end
        if (sel) q_b.push_back(3'b101);
        else q_a.push_back(3'b101);
    endtask

    // Drives a one-cycle load; the model accepts it only if that instance is idle.
    task automatic pulse_load(input bit sel, input logic [7:0] d, input logic par);
        if (sel) begin
            load_b = 1'b1;
            data_b = d;
            if (rst_n && q_b.size() == 0) push_frame(1'b1, d, par);
        end else begin
            load_a = 1'b1;
            data_a = d;
            if (rst_n && q_a.size() == 0) push_frame(1'b0, d, par);
        end
        sync();
        load_a = 1'b0;
        load_b = 1'b0;
        // Scramble the inputs so a frame that re-reads tx_data shows up.
        data_a = 8'($urandom);
        data_b = 8'($urandom);
    endtask

    task automatic wait_idle(input bit sel);
        int cnt;
        cnt = 0;
        while ((sel ? q_b.size() : q_a.size()) != 0 && cnt < 500) begin
            sync();
            cnt++;
        end
        if (cnt >= 500) begin
            n_total++;
            $display("FAIL wait_idle: model queue for sel=%0d not drained, required empty", sel);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        dones_a = 0;
        dones_b = 0;
        rst_n   = 1'b0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;

        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 1'b1, 1'b1};
        vecs[7] = '{8'h01, 1'b0, 1'b1};

        // Reset held 3 cycles with load toggling: nothing may start.
        for (int i = 0; i < 3; i++) begin
            sync();
            load_a = ~load_a;
            load_b = ~load_b;
            data_a = 8'hA5;
            data_b = 8'hA5;
        end
        sync();
        load_a = 1'b0;
        load_b = 1'b0;
        rst_n  = 1'b1;
        repeat (3) sync();
        check("reset_idle_a", 32'({tx_a, busy_a, done_a}), 32'h4);
        check("reset_idle_b", 32'({tx_b, busy_b, done_b}), 32'h4);

        // Single 0xA5 frame with a rejected load of 0xFF during the 5th data bit.
        before_a = dones_a;
        pulse_load(1'b0, 8'hA5, 1'b0);
        cap = '1;
        for (int k = 2; k <= int'(FrameLenA) + 1; k++) begin
            @(negedge clk);
            if (k % int'(Baud) == 2) cap[k / int'(Baud)] = tx_a;
            if (k == 22) begin
                #1;
                load_a = 1'b1;
                data_a = 8'hFF;
            end
            if (k == 23) begin
                #1;
                load_a = 1'b0;
            end
        end
`ifdef UART_TX_PARITY_EN
        exp_cap = 11'b10101001010;
`else
        exp_cap = 11'b11101001010;
`endif
        check("a5_bit_sequence", 32'(cap), 32'(exp_cap));
        sync();
        check("a5_single_done", 32'(dones_a - before_a), 32'd1);

        // Back-to-back on the 2-stop-bit instance: second load lands in the done cycle.
        wait_idle(1'b1);
        before_b = dones_b;
        pulse_load(1'b1, 8'h00, 1'b1);
        n = 0;
        while (!done_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL b2b_done_timeout: no tx_done within 200 cycles, required one");
        end
        #1;
        pulse_load(1'b1, 8'hFF, 1'b1);
        wait_idle(1'b1);
        sync();
        check("b2b_done_count", 32'(dones_b - before_b), 32'd2);

        // Reset during the 3rd data bit (a 0 bit of 0x5A) aborts the frame immediately.
        wait_idle(1'b0);
        before_a = dones_a;
        pulse_load(1'b0, 8'h5A, 1'b0);
        repeat (12) sync();
        check("pre_reset_tx", 32'(tx_a), 32'd0);
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        #1;
        check("async_reset", 32'({tx_a, busy_a, done_a}), 32'h4);
        repeat (2) sync();
        rst_n = 1'b1;
        sync();
        pulse_load(1'b0, 8'h3C, 1'b0);
        wait_idle(1'b0);
        sync();
        check("post_reset_done", 32'(dones_a - before_a), 32'd1);

        // Table of frames, alternating instances.
        before_a = dones_a;
        before_b = dones_b;
        frames_a = 0;
        frames_b = 0;
        for (int i = 0; i < 8; i++) begin
            wait_idle(vecs[i].sel);
            pulse_load(vecs[i].sel, vecs[i].data, vecs[i].par);
            if (vecs[i].sel) frames_b++;
            else frames_a++;
        end
        wait_idle(1'b0);
        wait_idle(1'b1);
        repeat (4) sync();
        check("table_done_a", 32'(dones_a - before_a), 32'(frames_a));
        check("table_done_b", 32'(dones_b - before_b), 32'(frames_b));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmit side of the UART: accepts one byte on a single-cycle load strobe and shifts it out as an asynchronous frame (start bit, 8 data bits LSB first, stop bits).
- Sits downstream of the positive-edge detectors that turn button/level requests into one-clock strobes, and opposite the UART receive path on the serial line.

Parameters:
- BAUD_DIV, 5208, clocks per bit period (50 MHz / 9600 baud); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- load  input  1  single-cycle transmit request; only sampled in IDLE.
- tx_data  input  8  byte to send; captured on the edge where load is accepted.
- tx  output  1  serial line, registered; idle high.
- tx_busy  output  1  high from load acceptance until frame end.
- tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, tx=1, tx_busy=0, tx_done=0, baud counter=0, bit counter=0, shift register=0. Reset mid-frame aborts the frame: tx returns high at once, and no tx_done is issued.
- States:
  - IDLE: tx=1. Transitions to START.
  - START: tx=0 for BAUD_DIV clocks.
  - DATA: 8 bits, each held BAUD_DIV clocks, shift register LSB first.
  - PAR: present only with the optional feature.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV clocks.
- Acceptance: on rising edge N with state=IDLE and load=1:
  - tx_data is latched into the shift register.
  - tx goes to 0, tx_busy goes to 1, state goes to START.
  - The baud counter is cleared.
- Baud counter: counts 0..BAUD_DIV-1; the bit boundary occurs at BAUD_DIV-1, then the counter wraps to 0. Its width is clog2(BAUD_DIV).
- Bit counter: 3 bits, counts data bits 0..7. Leave DATA when it is 7 and a bit boundary occurs.
- Frame length: (1+8+STOP_BITS)*BAUD_DIV clocks, plus BAUD_DIV more with parity. Edge N+FrameLen sets state to IDLE, tx_busy to 0 and tx_done to 1 for exactly one cycle.
- Back-to-back frames: load=1 in the cycle where tx_done=1 (state IDLE) is accepted. The next start bit begins with no idle gap beyond the full stop period.
- Load while busy: ignored. tx_data changes while busy have no effect on the frame.
- Simultaneous reset and load: reset wins.
- tx is glitch-free: it is driven directly from a flop and only changes at bit boundaries.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0) is added.
  - The PAR state is inserted between DATA and STOP for one bit period.
  - tx = ^tx_data_latched XOR PARITY_ODD, i.e. even parity by default.
  - Frame length grows by BAUD_DIV.
- When undefined:
  - No PAR state, no parity logic and no PARITY_ODD parameter.
  - DATA goes directly to STOP.

Test Plan:
- Reset: hold rst=0 for 3 cycles, toggle load during reset, release → tx=1, tx_busy=0, tx_done=0, and no frame starts.
- Single frame: BAUD_DIV=4, STOP_BITS=1, tx_data=8'hA5, load pulse at edge N → tx sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 clocks starting at N. tx_busy high for edges N..N+39; tx_done=1 in exactly the cycle after edge N+40.
- Busy rejection: during the 0xA5 frame, pulse load with tx_data=8'hFF at the 5th data bit → waveform identical to the single-frame case, and only one tx_done.
- Back-to-back: load 8'h00 and, in the tx_done cycle, load 8'hFF, with STOP_BITS=2 → the stop high lasts 8 clocks, then the next start bit begins immediately; the second frame has data bits all 1.
- Reset mid-frame: assert rst=0 during the 3rd data bit → tx=1 asynchronously, tx_busy=0, no tx_done. After release, a new load of 8'h3C transmits a correct frame.
- Parity (UART_TX_PARITY_EN defined, PARITY_ODD=0): tx_data=8'h07 → parity bit 1; with PARITY_ODD=1 → parity bit 0. Frame length is 44 clocks at BAUD_DIV=4, STOP_BITS=1.
